// File: rtl/uart_pkg.sv
// Shared UART definitions: default framing constants, FSM state codes and
// a small width helper used by the receiver and the future transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_OVERSAMPLE    = 16;
  localparam int UART_CLKS_PER_TICK = 27;

  typedef logic [1:0] uart_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Counter width for a range of n values; never narrower than one bit so a
  // degenerate range of 1 still yields a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every CLKS_PER_TICK clocks.
// A clear realigns the phase so the first tick lands a full tick period
// after the clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = clog2_min1(CLKS_PER_TICK);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  // Free-running divider counter, wrapping at LAST, restarted by clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, detects the start edge,
// samples each bit at its centre using an oversample tick and presents the
// assembled word with a one-clk valid or frame-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = UART_DATA_BITS,
  parameter int OVERSAMPLE    = UART_OVERSAMPLE,
  parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int            TW     = clog2_min1(OVERSAMPLE);
  localparam int            BW     = clog2_min1(DATA_BITS);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_sync_p0;
  logic                 rx_sync_p1;
  logic                 rx_prev_p2;
  logic                 rx_s;
  logic                 start_edge;
  logic                 tick;
  logic                 tick_clear;
  uart_state_t          state;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_centre;

  // Two-flop synchroniser plus previous-sample flop for edge detection.
  // All three idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev_p2 <= 1'b1;
    end else begin
      // stage p0 -> p1: metastability settling
      rx_sync_p0 <= rx;
      rx_sync_p1 <= rx_sync_p0;
      // stage p1 -> p2: history for falling-edge detect
      rx_prev_p2 <= rx_sync_p1;
    end
  end

  assign rx_s       = rx_sync_p1;
  assign start_edge = rx_prev_p2 && !rx_s;
  assign tick_clear = (state == ST_IDLE) && start_edge;
  assign bit_centre = tick && (tcnt == T_LAST);

  uart_baud_tick #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Receive FSM: start-bit qualification, data bit counting, stop check and
  // the output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      data_out    <= '0;
      tcnt        <= '0;
      bcnt        <= '0;
    end else begin
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state <= ST_START;
            busy  <= 1'b1;
            tcnt  <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tcnt == T_HALF) begin
              // Middle of the start bit: a high line means a glitch.
              if (rx_s) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_DATA;
                tcnt  <= '0;
                bcnt  <= '0;
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (bit_centre) begin
            tcnt <= '0;
            if (bcnt == B_LAST) begin
              state <= ST_STOP;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else if (tick) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        ST_STOP: begin
          if (bit_centre) begin
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
            tcnt  <= '0;
          end else if (tick) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Data shift register, LSB first: each centre sample enters at the MSB.
  always_ff @(posedge clk) begin
    if ((state == ST_DATA) && bit_centre) begin
      shreg <= {rx_s, shreg[DATA_BITS-1:1]};
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx with a fast tick (4 clk per
// tick, 64 clk per bit). Frames are generated from byte values; expected
// words, strobe counts and timing come from the framing rules.
module tb_uart_rx;

  localparam int CPT      = 4;
  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int BIT_CLKS = OS * CPT;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          rx    = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_error;
  logic          busy;

  int            checks = 0;
  int            passed = 0;
  int            cyc    = 0;
  logic [DB-1:0] dv_q[$];
  int            dvc_q[$];
  int            fe_cnt   = 0;
  int            both_cnt = 0;
  logic [DB-1:0] last_good = '0;

  uart_rx #(
    .DATA_BITS     (DB),
    .OVERSAMPLE    (OS),
    .CLKS_PER_TICK (CPT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (data_valid) begin
      dv_q.push_back(data_out);
      dvc_q.push_back(cyc);
    end
    if (frame_error) fe_cnt++;
    if (data_valid && frame_error) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    dv_q.delete();
    dvc_q.delete();
    fe_cnt   = 0;
    both_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
  endtask

  // Outcome of exactly one frame since the last clear_mon.
  task automatic expect_frame(input string tag, input bit good, input logic [DB-1:0] d);
    repeat (4) @(negedge clk);
    chk({tag, " valid count"}, dv_q.size(), good ? 1 : 0);
    chk({tag, " error count"}, fe_cnt, good ? 0 : 1);
    if (dv_q.size() > 0) chk({tag, " strobed word"}, dv_q[0], d);
    chk({tag, " data_out"}, data_out, good ? d : last_good);
    chk({tag, " busy idle"}, busy, 1'b0);
    chk({tag, " exclusive strobes"}, both_cnt, 0);
    if (good) last_good = d;
  endtask

  initial begin
    int            fall;
    int            lat;
    int            gap;
    logic [DB-1:0] rd;
    bit            rgood;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset data_out", data_out, '0);
    chk("reset data_valid", data_valid, 1'b0);
    chk("reset frame_error", frame_error, 1'b0);
    chk("reset busy", busy, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Clean frame 0xA5 with latency and busy checks
    clear_mon();
    fall = cyc;
    send_bit(1'b0);
    chk("A5 busy in frame", busy, 1'b1);
    for (int i = 0; i < DB; i++) send_bit(rd_bit(8'hA5, i));
    send_bit(1'b1);
    expect_frame("A5", 1'b1, 8'hA5);
    lat = (dvc_q.size() > 0) ? dvc_q[0] - fall : -1;
    chk("A5 latency window", (lat >= 2 + 608 - 2) && (lat <= 2 + 608 + 2), 1'b1);
    repeat (BIT_CLKS) @(negedge clk);

    // Glitch shorter than half a bit
    clear_mon();
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch busy cleared", busy, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("glitch no valid", dv_q.size(), 0);
    chk("glitch no error", fe_cnt, 0);

    // Stop bit low: frame error, data_out holds
    clear_mon();
    send_frame(8'h3C, 1'b0);
    expect_frame("3C badstop", 1'b0, 8'h3C);
    repeat (BIT_CLKS) @(negedge clk);

    // Back-to-back frames, no idle bits
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    chk("b2b valid count", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      chk("b2b first word", dv_q[0], 8'h00);
      chk("b2b second word", dv_q[1], 8'hFF);
      gap = dvc_q[1] - dvc_q[0];
      chk("b2b strobe spacing", (gap >= 10 * BIT_CLKS - 1) && (gap <= 10 * BIT_CLKS + 1), 1'b1);
    end
    chk("b2b data_out", data_out, 8'hFF);
    last_good = 8'hFF;
    repeat (BIT_CLKS) @(negedge clk);

    // Reset pulse during data bit 4 of 0x5A; sender then goes idle
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rd_bit(8'h5A, i));
    rx = rd_bit(8'h5A, 4);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset data_out", data_out, '0);
    chk("midreset data_valid", data_valid, 1'b0);
    chk("midreset frame_error", frame_error, 1'b0);
    chk("midreset busy", busy, 1'b0);
    rx = 1'b1;
    last_good = '0;
    repeat (12 * BIT_CLKS) @(negedge clk);
    chk("midreset no valid", dv_q.size(), 0);
    chk("midreset no error", fe_cnt, 0);
    clear_mon();
    send_frame(8'h81, 1'b1);
    expect_frame("81 after reset", 1'b1, 8'h81);
    repeat (BIT_CLKS) @(negedge clk);

    // Line held low (break) for 30 bit periods
    clear_mon();
    rx = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    chk("break error count", fe_cnt, 1);
    chk("break no valid", dv_q.size(), 0);
    chk("break busy idle", busy, 1'b0);
    chk("break data_out held", data_out, 8'h81);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("break no extra error", fe_cnt, 1);
    clear_mon();
    send_frame(8'h7E, 1'b1);
    expect_frame("7E after break", 1'b1, 8'h7E);

    // Randomized frames: random data, occasional bad stop, random idle gap
    for (int n = 0; n < 12; n++) begin
      rd    = DB'($urandom_range(0, 255));
      rgood = ($urandom_range(0, 3) != 0);
      clear_mon();
      send_frame(rd, rgood);
      expect_frame($sformatf("rand%0d", n), rgood, rd);
      repeat ((rgood ? $urandom_range(0, 2) : $urandom_range(1, 2)) * BIT_CLKS) @(negedge clk);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  function automatic logic rd_bit(input logic [DB-1:0] d, input int i);
    return d[i];
  endfunction

endmodule
